dual_port_ram_clr: RTL and testbench
====================================

Name: dual_port_ram_clr

Overview:
Behavioural true-dual-port RAM, the successor to the vendor-macro RAM wrappers. Adds byte-lane write enables, selectable read-first/write-first mode and deterministic cross-port collision rules. Adds a 1- or 2-stage read pipeline and a hardware clear-on-reset sweep. Intended for cache tag/valid arrays and the TLB, which must come up zeroed without software initialisation.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
DEPTH, 128, number of words; power of two, >= 2.
BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
LATENCY, 1, read latency in cycles; legal values 1 or 2.
WRITE_MODE, "read_first", same-port read-during-write result; legal values "read_first" or "write_first".
CLEAR_ON_RESET, 1, 1 = sweep every word to CLEAR_VALUE after reset.
CLEAR_VALUE, 0, DATA_WIDTH-bit value written during the sweep.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
ena  in  1  port A enable.
enb  in  1  port B enable.
wea  in  NB  port A byte write enables; qualified by ena.
web  in  NB  port B byte write enables; qualified by enb.
addra  in  $clog2(DEPTH)  port A address.
addrb  in  $clog2(DEPTH)  port B address.
dina  in  DATA_WIDTH  port A write data.
dinb  in  DATA_WIDTH  port B write data.
douta  out  DATA_WIDTH  port A read data.
doutb  out  DATA_WIDTH  port B read data.
busy  out  1  high while the clear sweep runs; user access is ignored.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high. No asynchronous logic.
- FSM states: READY and CLEAR.
  - rst sampled high: state <= CLEAR if CLEAR_ON_RESET, else READY; clear counter <= 0; all output pipeline registers <= 0.
  - Memory array contents are not reset.
- Reset values: douta = 0, doutb = 0, busy = CLEAR_ON_RESET.
- CLEAR state (rst low):
  - Each cycle writes CLEAR_VALUE to mem[cnt], then cnt++.
  - The cycle that writes cnt == DEPTH-1 moves the FSM to READY; the sweep takes exactly DEPTH cycles after rst deasserts.
  - busy = (state == CLEAR), registered.
  - ena/enb/wea/web are ignored; douta/doutb hold 0.
- rst asserted mid-sweep: counter restarts at 0; a full DEPTH-cycle sweep follows the deassertion.
- Writes (READY): for each lane i with ena & wea[i], mem[addra] lane i <= dina lane i. Port B is the same with enb/web/addrb/dinb.
- Collision: both ports write the same address in the same cycle → per lane, port A wins; port B's lane is written only where wea[i] = 0.
- Stage-1 read register, port A: loads when ena = 1; holds when ena = 0.
  - Same-port read-during-write:
    - read_first → pre-write word.
    - write_first → merged word (new data on written lanes, old data on the rest).
  - Cross-port read of an address the other port writes in the same cycle → always the pre-write word, in either mode.
- Port B read path: symmetric to port A.
- LATENCY = 1: dout = stage-1 register.
- LATENCY = 2: a stage-2 register loads stage 1 on the cycle after stage 1 was loaded (delayed enable) and holds otherwise; dout = stage-2 register.
- Enable low: no read and no write on that port; dout holds its last value.
- Illegal parameters (LATENCY not 1 or 2, DATA_WIDTH % BYTE_WIDTH != 0, DEPTH not a power of two) → elaboration-time $error.

Decomposition:
- Package dpram_pkg:
  - write-mode string constants RD_FIRST and WR_FIRST;
  - function nbytes(width, byte_width);
  - function byte_merge(old, new, be, byte_width) returning the lane-merged word (used both for memory writes and for write_first forwarding).
- Sub-module dpram_out_pipe (params DATA_WIDTH, LATENCY; ports clk, rst, ld, d, q):
  - implements the stage-1/stage-2 read registers with delayed enable and reset-to-0;
  - instantiated once per port.
- Top level holds the array, the clear FSM/counter and the collision logic.

Test Plan:
All scenarios use DATA_WIDTH = 32, DEPTH = 16 unless stated.
1. Clear sweep: CLEAR_VALUE = 32'hDEADBEEF; rst high 1 cycle → busy = 1 for exactly 16 cycles, then 0. Reading addrs 0..15 on both ports → every word is 32'hDEADBEEF.
2. Byte write: mem[3] = 32'hAABBCCDD; port A wea = 4'b0101, dina = 32'h11223344 → next read of addr 3 on port B = 32'hAA22CC44.
3. Write mode: mem[5] = 0; port A ena = 1, wea = 4'hF, dina = 32'h12345678 → douta next cycle = 32'h12345678 (write_first) or 0 (read_first). Same cycle, port B reads addr 5 → doutb = 0 in both modes.
4. Collision: A writes 32'h11111111 with wea = 4'b0011 and B writes 32'h22222222 with web = 4'b1111, both at addr 7 → mem[7] = 32'h22221111.
5. Reset mid-sweep: rst asserted at sweep cycle 8 → busy stays high 16 cycles after rst deasserts. A port A write of 32'hFFFFFFFF to addr 0 during busy → addr 0 still reads CLEAR_VALUE afterwards.
6. LATENCY = 2: mem[2] = 32'hCAFEF00D; ena pulsed 1 cycle → douta = 32'hCAFEF00D exactly 2 cycles later and held while ena = 0.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the clear-on-reset true-dual-port RAM.
package dpram_pkg;

  // Same-port read-during-write modes.
  localparam string RD_FIRST = "read_first";
  localparam string WR_FIRST = "write_first";

  // Widest word / lane count the merge helper handles.
  localparam int MAX_DW = 256;
  localparam int MAX_NB = 256;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Number of write-enable lanes in a word.
  function automatic int nbytes(input int width, input int byte_width);
    return width / byte_width;
  endfunction

  // Lane-merge: lanes with be set take new_word, the rest keep old_word.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_word,
    input logic [MAX_DW-1:0] new_word,
    input logic [MAX_NB-1:0] be,
    input int                byte_width
  );
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int b = 0; b < MAX_DW; b++) begin
      if (be[b / byte_width]) begin
        res[b] = new_word[b];
      end else begin
        res[b] = old_word[b];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_out_pipe.sv
// Read-data output pipeline: stage 1 loads on ld; optional stage 2 loads
// stage 1 on the cycle after stage 1 was loaded.
module dpram_out_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] stage1_r;

  // Stage-1 read register: captures the read word whenever the port is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_r <= '0;
    end else if (ld) begin
      stage1_r <= d;
    end else begin
      stage1_r <= stage1_r;
    end
  end

  if (LATENCY == 2) begin : g_two
    logic                  ld_d_r;
    logic [DATA_WIDTH-1:0] stage2_r;

    // Stage-2 register follows stage 1 one cycle after each stage-1 load.
    always_ff @(posedge clk) begin
      if (rst) begin
        ld_d_r   <= 1'b0;
        stage2_r <= '0;
      end else begin
        ld_d_r <= ld;
        if (ld_d_r) begin
          stage2_r <= stage1_r;
        end else begin
          stage2_r <= stage2_r;
        end
      end
    end

    assign q = stage2_r;
  end else begin : g_one
    assign q = stage1_r;
  end

endmodule

// File: rtl/dual_port_ram_clr.sv
// True-dual-port RAM with byte-lane writes, read-first/write-first mode,
// port-A-wins collision handling and a hardware clear sweep after reset.
module dual_port_ram_clr
  import dpram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    DEPTH          = 128,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    LATENCY        = 1,
  parameter string                 WRITE_MODE     = "read_first",
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic                             enb,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] web,
  input  logic [$clog2(DEPTH)-1:0]         addra,
  input  logic [$clog2(DEPTH)-1:0]         addrb,
  input  logic [DATA_WIDTH-1:0]            dina,
  input  logic [DATA_WIDTH-1:0]            dinb,
  output logic [DATA_WIDTH-1:0]            douta,
  output logic [DATA_WIDTH-1:0]            doutb,
  output logic                             busy
);

  localparam int NB = nbytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam bit WF = (WRITE_MODE == WR_FIRST);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  if ((LATENCY != 1) && (LATENCY != 2)) begin : g_bad_latency
    $error("dual_port_ram_clr: LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("dual_port_ram_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("dual_port_ram_clr: DEPTH must be a power of two >= 2");
  end
  if ((WRITE_MODE != RD_FIRST) && (WRITE_MODE != WR_FIRST)) begin : g_bad_mode
    $error("dual_port_ram_clr: WRITE_MODE must be read_first or write_first");
  end

  // Module-width wrapper around the package lane-merge helper.
  function automatic logic [DATA_WIDTH-1:0] merge_w(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be
  );
    return DATA_WIDTH'(byte_merge(MAX_DW'(old_word), MAX_DW'(new_word),
                                  MAX_NB'(be), BYTE_WIDTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_state_t            state_r;
  logic [AW-1:0]         cnt_r;
  logic                  busy_r;

  logic                  ready_s;
  logic                  same_s;
  logic [NB-1:0]         be_a_s;
  logic [NB-1:0]         be_b_s;
  logic [DATA_WIDTH-1:0] old_a_s;
  logic [DATA_WIDTH-1:0] old_b_s;
  logic [DATA_WIDTH-1:0] new_a_s;
  logic [DATA_WIDTH-1:0] new_b_s;
  logic [DATA_WIDTH-1:0] both_s;
  logic [DATA_WIDTH-1:0] rd_a_s;
  logic [DATA_WIDTH-1:0] rd_b_s;
  logic                  ld_a_s;
  logic                  ld_b_s;

  // Clear-sweep FSM: walks every address once after reset, then idles in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_r   <= '0;
      busy_r  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_r)
        CLEAR: begin
          cnt_r <= cnt_r + AW'(1);
          if (cnt_r == LAST_ADDR) begin
            state_r <= READY;
            busy_r  <= 1'b0;
          end else begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
          end
        end
        READY: begin
          state_r <= READY;
          cnt_r   <= cnt_r;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= READY;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Effective lane enables, collision resolution and read-word selection.
  // Port B loses every lane port A also writes at the same address; the
  // write-first forward only shows the lanes a port actually commits.
  always_comb begin
    ready_s = (state_r == READY) && !rst;
    same_s  = (addra == addrb);
    be_a_s  = (ready_s && ena) ? wea : '0;
    be_b_s  = (ready_s && enb) ? web : '0;
    be_b_s  = same_s ? (be_b_s & ~be_a_s) : be_b_s;
    old_a_s = mem[addra];
    old_b_s = mem[addrb];
    new_a_s = merge_w(old_a_s, dina, be_a_s);
    new_b_s = merge_w(old_b_s, dinb, be_b_s);
    both_s  = merge_w(new_a_s, dinb, be_b_s);
    rd_a_s  = WF ? new_a_s : old_a_s;
    rd_b_s  = WF ? new_b_s : old_b_s;
    ld_a_s  = ready_s && ena;
    ld_b_s  = ready_s && enb;
  end

  // Memory array update: sweep writes, then user writes with A-wins merging.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == CLEAR)) begin
      mem[cnt_r] <= CLEAR_VALUE;
    end else if (same_s && ((|be_a_s) || (|be_b_s))) begin
      mem[addra] <= both_s;
    end else begin
      if (|be_a_s) begin
        mem[addra] <= new_a_s;
      end
      if (|be_b_s) begin
        mem[addrb] <= new_b_s;
      end
    end
  end

  dpram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_pipe_a (
    .clk (clk),
    .rst (rst),
    .ld  (ld_a_s),
    .d   (rd_a_s),
    .q   (douta)
  );

  dpram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_pipe_b (
    .clk (clk),
    .rst (rst),
    .ld  (ld_b_s),
    .d   (rd_b_s),
    .q   (doutb)
  );

  assign busy = busy_r;

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Bench for dual_port_ram_clr: two instances share one stimulus stream,
// one read_first / latency 1, one write_first / latency 2.
module tb_dual_port_ram_clr;

  localparam int          DW = 32;
  localparam int          D  = 16;
  localparam logic [31:0] CV = 32'hDEADBEEF;

  logic        clk;
  logic        rst;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [3:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta1, doutb1, douta2, doutb2;
  logic        busy1, busy2;

  int checks   = 0;
  int failures = 0;

  dual_port_ram_clr #(
    .DATA_WIDTH(DW), .DEPTH(D), .BYTE_WIDTH(8), .LATENCY(1),
    .WRITE_MODE("read_first"), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut_rf (
    .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta1), .doutb(doutb1), .busy(busy1)
  );

  dual_port_ram_clr #(
    .DATA_WIDTH(DW), .DEPTH(D), .BYTE_WIDTH(8), .LATENCY(2),
    .WRITE_MODE("write_first"), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut_wf (
    .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta2), .doutb(doutb2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [31:0] mem_m [D];
  int          sweep_idx = 0;
  logic [31:0] last_rf_a = 32'h0, last_rf_b = 32'h0;
  logic [31:0] last_wf_a = 32'h0, last_wf_b = 32'h0;
  logic [31:0] exp2_a = 32'h0, exp2_b = 32'h0;
  bit          model_chk = 1'b0;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [31:0] pre_a, pre_b, ma, mb, wf_a, wf_b;
    if (rst) begin
      sweep_idx = 0;
      last_rf_a = 32'h0; last_rf_b = 32'h0;
      last_wf_a = 32'h0; last_wf_b = 32'h0;
      exp2_a    = 32'h0; exp2_b    = 32'h0;
    end else begin
      // latency-2 output shows the last value loaded before this edge
      exp2_a = last_wf_a;
      exp2_b = last_wf_b;
      if (sweep_idx < D) begin
        mem_m[sweep_idx] = CV;
        sweep_idx++;
      end else begin
        pre_a = mem_m[addra];
        pre_b = mem_m[addrb];
        ma = ena ? lane_mask(wea) : 32'h0;
        mb = enb ? lane_mask(web) : 32'h0;
        if (addra == addrb) mb = mb & ~ma;
        wf_a = (pre_a & ~ma) | (dina & ma);
        wf_b = (pre_b & ~mb) | (dinb & mb);
        mem_m[addra] = wf_a;
        mem_m[addrb] = (mem_m[addrb] & ~mb) | (dinb & mb);
        if (ena) begin
          last_rf_a = pre_a;
          last_wf_a = wf_a;
        end
        if (enb) begin
          last_rf_b = pre_b;
          last_wf_b = wf_b;
        end
      end
    end
  endtask

  // One clock: update model at the edge, compare 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (model_chk) begin
      check("model_busy_rf", {31'h0, busy1}, {31'h0, (sweep_idx < D)});
      check("model_busy_wf", {31'h0, busy2}, {31'h0, (sweep_idx < D)});
      check("model_douta_rf", douta1, last_rf_a);
      check("model_doutb_rf", doutb1, last_rf_b);
      check("model_douta_wf", douta2, exp2_a);
      check("model_doutb_wf", doutb2, exp2_b);
    end
  endtask

  task automatic idle_inputs();
    ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    addra = 4'h0; addrb = 4'h0; dina = 32'h0; dinb = 32'h0;
  endtask

  typedef struct {
    logic        ena, enb;
    logic [3:0]  wea, web, addra, addrb;
    logic [31:0] dina, dinb;
    logic [31:0] xa1, xb1, xa2, xb2;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int n;
    // directed vectors, starting from a freshly swept array of CV words
    vecs[0]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'd3, 4'd0, 32'hAABBCCDD, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b1, 4'h5, 4'h0, 4'd3, 4'd3, 32'h11223344, 32'h0, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'd0, 4'd3, 32'h0, 32'h0, 32'hAABBCCDD, 32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD};
    vecs[3]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'd5, 4'd0, 32'h0, 32'h0, 32'hDEADBEEF, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'd5, 4'd5, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'hAA22CC44};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 4'h3, 4'hF, 4'd7, 4'd7, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'd7, 4'd0, 32'h0, 32'h0, 32'h22221111, 32'hDEADBEEF, 32'hDEAD1111, 32'h2222BEEF};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h22221111, 32'hDEADBEEF, 32'h22221111, 32'h2222BEEF};
    vecs[9]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'd2, 4'd0, 32'hCAFEF00D, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h22221111, 32'h2222BEEF};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hCAFEF00D, 32'h2222BEEF};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'd7, 4'd0, 32'h0, 32'h0, 32'h22221111, 32'hDEADBEEF, 32'hCAFEF00D, 32'h2222BEEF};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'd2, 4'd0, 32'h0, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF, 32'h22221111, 32'h2222BEEF};
    vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'h2222BEEF};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'h2222BEEF};

    // reset state
    idle_inputs();
    rst = 1'b1;
    cycle();
    check("reset_busy_rf", {31'h0, busy1}, 32'h1);
    check("reset_busy_wf", {31'h0, busy2}, 32'h1);
    check("reset_douta_rf", douta1, 32'h0);
    check("reset_doutb_rf", doutb1, 32'h0);
    check("reset_douta_wf", douta2, 32'h0);
    check("reset_doutb_wf", doutb2, 32'h0);
    rst = 1'b0;
    model_chk = 1'b1;

    // clear sweep length, with port traffic that must be ignored
    ena = 1'b1; enb = 1'b1; wea = 4'hF; web = 4'hF;
    addra = 4'd1; addrb = 4'd9; dina = 32'h0BAD0BAD; dinb = 32'h0BAD0BAD;
    n = 0;
    while (busy1 && n < 40) begin
      cycle();
      n++;
    end
    check("sweep_len", n, 32'd16);
    check("sweep_end_busy_wf", {31'h0, busy2}, 32'h0);
    idle_inputs();

    // read back every word on both ports
    for (int i = 0; i < D; i++) begin
      ena = 1'b1; enb = 1'b1;
      addra = 4'(i); addrb = 4'(D - 1 - i);
      cycle();
      check($sformatf("readback_a_%0d", i), douta1, CV);
      check($sformatf("readback_b_%0d", D - 1 - i), doutb1, CV);
    end

    // directed table: byte write, write modes, collision, latency-2 pulse
    for (int v = 0; v < 15; v++) begin
      ena = vecs[v].ena; enb = vecs[v].enb; wea = vecs[v].wea; web = vecs[v].web;
      addra = vecs[v].addra; addrb = vecs[v].addrb;
      dina = vecs[v].dina; dinb = vecs[v].dinb;
      cycle();
      check($sformatf("vec%0d_douta_rf", v), douta1, vecs[v].xa1);
      check($sformatf("vec%0d_doutb_rf", v), doutb1, vecs[v].xb1);
      check($sformatf("vec%0d_douta_wf", v), douta2, vecs[v].xa2);
      check($sformatf("vec%0d_doutb_wf", v), doutb2, vecs[v].xb2);
    end

    // reset mid-sweep, with a write attempt while busy
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ena = 1'b1; wea = 4'hF; addra = 4'd0; dina = 32'hFFFFFFFF;
    n = 0;
    while (busy1 && n < 40) begin
      cycle();
      n++;
    end
    check("resweep_len", n, 32'd16);
    wea = 4'h0; dina = 32'h0;
    cycle();
    check("resweep_addr0_rf", douta1, CV);
    ena = 1'b0;
    cycle();
    check("resweep_addr0_wf", douta2, CV);

    // randomized traffic against the model, biased toward address collisions
    for (int i = 0; i < 400; i++) begin
      ena = 1'($urandom_range(0, 1));
      enb = 1'($urandom_range(0, 1));
      wea = 4'($urandom_range(0, 15));
      web = 4'($urandom_range(0, 15));
      addra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      addrb = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      dina = $urandom;
      dinb = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
